// File: rtl/pipeline_control_unit.sv
// Pipelined RV32I control unit: decodes in D, carries control through D/E, M1..M(MEM_LAT)
// and M/W registers, and resolves branches in E.
// Optional feature macro: CTRL_SHIFT_EN adds sll/srl/sra and slli/srli/srai decoding.
module pipeline_control_unit #(
  parameter int unsigned ALU_CTRL_W = 3,
  parameter int unsigned MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            opD,
  input  logic [2:0]            funct3D,
  input  logic [6:0]            funct7D,
  input  logic                  FlushE,
  input  logic                  ZeroE,
  input  logic                  LessThanE,
  input  logic                  LessThanUE,
  output logic [2:0]            ImmSrcD,
  output logic                  IllegalD,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic                  ALUSrcE,
  output logic                  JalrE,
  output logic                  PCSrcE,
  output logic                  ResultSrcE0,
  output logic                  MemWriteM,
  output logic                  RegWriteM,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW,
  output logic                  IllegalW
);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_mem_lat_check
    $error("MEM_LAT must be in 1..4");
  end

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmU = 3'b011;
  localparam logic [2:0] ImmJ = 3'b100;

  localparam logic [1:0] ResMem = 2'b01;
  localparam logic [1:0] ResPc4 = 2'b10;
  localparam logic [1:0] ResImm = 2'b11;

  localparam logic [ALU_CTRL_W-1:0] AluAdd  = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] AluSub  = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] AluAnd  = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] AluOr   = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] AluSltu = ALU_CTRL_W'(4);
  localparam logic [ALU_CTRL_W-1:0] AluSlt  = ALU_CTRL_W'(5);
  localparam logic [ALU_CTRL_W-1:0] AluXor  = ALU_CTRL_W'(6);

`ifdef CTRL_SHIFT_EN
  if (ALU_CTRL_W < 4) begin : g_alu_w_check
    $error("ALU_CTRL_W must be >= 4 when CTRL_SHIFT_EN is defined");
  end
  localparam logic [ALU_CTRL_W-1:0] AluSll = ALU_CTRL_W'(8);
  localparam logic [ALU_CTRL_W-1:0] AluSrl = ALU_CTRL_W'(9);
  localparam logic [ALU_CTRL_W-1:0] AluSra = ALU_CTRL_W'(10);
`endif

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic                  jalr;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  alu_src;
    logic [2:0]            funct3;
    logic                  illegal;
  } e_ctrl_t;

  // Control that survives past E; MemWrite is only needed in M1 and is kept apart.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       illegal;
  } m_ctrl_t;

  e_ctrl_t    dec;
  logic [2:0] imm_src;
  e_ctrl_t    e_d, e_q;
  m_ctrl_t    m_d [MEM_LAT];
  m_ctrl_t    m_q [MEM_LAT];
  logic       mem_write_m_d, mem_write_m_q;
  m_ctrl_t    w_d, w_q;
  logic       branch_cond;

  // D-stage decode; an illegal encoding collapses to a bubble carrying only the illegal flag.
  always_comb begin
    dec        = '0;
    imm_src    = ImmI;
    dec.funct3 = funct3D;
    case (opD)
      OpReg: begin
        dec.reg_write = 1'b1;
        case ({funct7D, funct3D})
          {F7Base, 3'b000}: dec.alu_ctrl = AluAdd;
          {F7Alt,  3'b000}: dec.alu_ctrl = AluSub;
          {F7Base, 3'b111}: dec.alu_ctrl = AluAnd;
          {F7Base, 3'b110}: dec.alu_ctrl = AluOr;
          {F7Base, 3'b011}: dec.alu_ctrl = AluSltu;
          {F7Base, 3'b010}: dec.alu_ctrl = AluSlt;
          {F7Base, 3'b100}: dec.alu_ctrl = AluXor;
`ifdef CTRL_SHIFT_EN
          {F7Base, 3'b001}: dec.alu_ctrl = AluSll;
          {F7Base, 3'b101}: dec.alu_ctrl = AluSrl;
          {F7Alt,  3'b101}: dec.alu_ctrl = AluSra;
`endif
          default:          dec.illegal  = 1'b1;
        endcase
      end
      OpImm: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        case (funct3D)
          3'b000:  dec.alu_ctrl = AluAdd;
          3'b010:  dec.alu_ctrl = AluSlt;
          3'b011:  dec.alu_ctrl = AluSltu;
          3'b100:  dec.alu_ctrl = AluXor;
          3'b110:  dec.alu_ctrl = AluOr;
          3'b111:  dec.alu_ctrl = AluAnd;
`ifdef CTRL_SHIFT_EN
          // funct7D carries imm[11:5] for immediate shifts.
          3'b001: begin
            if (funct7D == F7Base) dec.alu_ctrl = AluSll;
            else                   dec.illegal  = 1'b1;
          end
          3'b101: begin
            if (funct7D == F7Base)     dec.alu_ctrl = AluSrl;
            else if (funct7D == F7Alt) dec.alu_ctrl = AluSra;
            else                       dec.illegal  = 1'b1;
          end
`endif
          default: dec.illegal = 1'b1;
        endcase
      end
      OpLoad: begin
        if (funct3D == 3'b010) begin
          dec.reg_write  = 1'b1;
          dec.alu_src    = 1'b1;
          dec.result_src = ResMem;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OpStore: begin
        if (funct3D == 3'b010) begin
          dec.alu_src   = 1'b1;
          dec.mem_write = 1'b1;
          imm_src       = ImmS;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OpJal: begin
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = ResPc4;
        imm_src        = ImmJ;
      end
      OpJalr: begin
        if (funct3D == 3'b000) begin
          dec.jump       = 1'b1;
          dec.jalr       = 1'b1;
          dec.alu_src    = 1'b1;
          dec.reg_write  = 1'b1;
          dec.result_src = ResPc4;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OpBranch: begin
        if (funct3D[2:1] == 2'b01) begin
          dec.illegal = 1'b1;
        end else begin
          dec.branch   = 1'b1;
          dec.alu_ctrl = AluSub;
          imm_src      = ImmB;
        end
      end
      OpLui: begin
        dec.reg_write  = 1'b1;
        dec.result_src = ResImm;
        imm_src        = ImmU;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
      imm_src     = ImmI;
    end
  end

  // Next-state for D/E (flush bubble) and the M/W shift chain.
  always_comb begin
    e_d           = FlushE ? '0 : dec;
    mem_write_m_d = e_q.mem_write;
    m_d[0]        = '{reg_write: e_q.reg_write, result_src: e_q.result_src,
                      illegal: e_q.illegal};
    for (int k = 1; k < MEM_LAT; k++) begin
      m_d[k] = m_q[k-1];
    end
    w_d = m_q[MEM_LAT-1];
  end

  // Pipeline registers; synchronous reset loads bubbles everywhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q           <= '0;
      mem_write_m_q <= 1'b0;
      for (int k = 0; k < MEM_LAT; k++) begin
        m_q[k] <= '0;
      end
      w_q <= '0;
    end else begin
      e_q           <= e_d;
      mem_write_m_q <= mem_write_m_d;
      for (int k = 0; k < MEM_LAT; k++) begin
        m_q[k] <= m_d[k];
      end
      w_q <= w_d;
    end
  end

  // Branch condition selected by the funct3 held in E.
  always_comb begin
    branch_cond = 1'b0;
    case (e_q.funct3)
      3'b000:  branch_cond = ZeroE;
      3'b001:  branch_cond = !ZeroE;
      3'b100:  branch_cond = LessThanE;
      3'b101:  branch_cond = !LessThanE;
      3'b110:  branch_cond = LessThanUE;
      3'b111:  branch_cond = !LessThanUE;
      default: branch_cond = 1'b0;
    endcase
  end

  assign ImmSrcD     = imm_src;
  assign IllegalD    = dec.illegal;
  assign ALUControlE = e_q.alu_ctrl;
  assign ALUSrcE     = e_q.alu_src;
  assign JalrE       = e_q.jalr;
  assign PCSrcE      = e_q.jump | (e_q.branch & branch_cond);
  assign ResultSrcE0 = e_q.result_src[0];
  assign MemWriteM   = mem_write_m_q;
  assign RegWriteM   = m_q[0].reg_write;
  assign RegWriteW   = w_q.reg_write;
  assign ResultSrcW  = w_q.result_src;
  assign IllegalW    = w_q.illegal;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Bench for pipeline_control_unit: two instances (MEM_LAT 1 and 3) share stimulus; a table-driven
// instruction model plus per-edge history predicts every output on every negedge.
module tb_pipeline_control_unit;

`ifdef CTRL_SHIFT_EN
  localparam int unsigned AW = 4;
`else
  localparam int unsigned AW = 3;
`endif

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic clk = 1'b0;
  logic rst, FlushE, ZeroE, LessThanE, LessThanUE;
  logic [6:0] opD, funct7D;
  logic [2:0] funct3D;

  logic [2:0] imm1, imm3;
  logic ill1, ill3, asrc1, asrc3, jalr1, jalr3, pc1, pc3, rse1, rse3;
  logic mw1, mw3, rwm1, rwm3, rww1, rww3, illw1, illw3;
  logic [AW-1:0] alu1, alu3;
  logic [1:0] rsw1, rsw3;

  always #5 clk = ~clk;

  pipeline_control_unit #(.ALU_CTRL_W(AW), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .opD(opD), .funct3D(funct3D), .funct7D(funct7D), .FlushE(FlushE),
    .ZeroE(ZeroE), .LessThanE(LessThanE), .LessThanUE(LessThanUE), .ImmSrcD(imm1),
    .IllegalD(ill1), .ALUControlE(alu1), .ALUSrcE(asrc1), .JalrE(jalr1), .PCSrcE(pc1),
    .ResultSrcE0(rse1), .MemWriteM(mw1), .RegWriteM(rwm1), .RegWriteW(rww1),
    .ResultSrcW(rsw1), .IllegalW(illw1)
  );

  pipeline_control_unit #(.ALU_CTRL_W(AW), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .opD(opD), .funct3D(funct3D), .funct7D(funct7D), .FlushE(FlushE),
    .ZeroE(ZeroE), .LessThanE(LessThanE), .LessThanUE(LessThanUE), .ImmSrcD(imm3),
    .IllegalD(ill3), .ALUControlE(alu3), .ALUSrcE(asrc3), .JalrE(jalr3), .PCSrcE(pc3),
    .ResultSrcE0(rse3), .MemWriteM(mw3), .RegWriteM(rwm3), .RegWriteW(rww3),
    .ResultSrcW(rsw3), .IllegalW(illw3)
  );

  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic       jmp;
    logic       br;
    logic       jalr;
    logic [3:0] alu;
    logic       asrc;
    logic [2:0] imm;
    logic       ill;
  } ctl_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    bit         f3_any;
    logic [6:0] f7;
    bit         f7_any;
    ctl_t       c;
  } ent_t;

  ent_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   edges  = 0;
  ctl_t e_hist  [0:2047];
  logic [2:0] f3_hist [0:2047];
  bit   rst_hist[0:2047];

  function automatic void add(logic [6:0] op, logic [2:0] f3, bit f3a, logic [6:0] f7, bit f7a,
                              logic rw, logic [1:0] rs, logic mw, logic jmp, logic br,
                              logic jalr, logic [3:0] alu, logic asrc, logic [2:0] imm);
    ent_t e;
    e.op = op; e.f3 = f3; e.f3_any = f3a; e.f7 = f7; e.f7_any = f7a;
    e.c = '{rw: rw, rs: rs, mw: mw, jmp: jmp, br: br, jalr: jalr, alu: alu, asrc: asrc,
            imm: imm, ill: 1'b0};
    tbl.push_back(e);
  endfunction

  function automatic ctl_t model_dec(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
    ctl_t r;
    r = '0;
    r.ill = 1'b1;
    foreach (tbl[i]) begin
      if (tbl[i].op == op && (tbl[i].f3_any || tbl[i].f3 == f3) &&
          (tbl[i].f7_any || tbl[i].f7 == f7)) r = tbl[i].c;
    end
    return r;
  endfunction

  function automatic bit taken(logic [2:0] f3, logic z, logic lt, logic ltu);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  // Control seen L edges after entering E: bubble if any reset hit it on the way.
  function automatic ctl_t late(int c, int l);
    for (int k = c - l; k <= c; k++) begin
      if (k < 1 || rst_hist[k]) return '0;
    end
    return e_hist[c-l-1];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Record what the D/E register should have loaded at each edge.
  always @(posedge clk) begin
    rst_hist[edges+1] <= rst;
    e_hist[edges+1]   <= (rst || FlushE) ? '0 : model_dec(opD, funct3D, funct7D);
    f3_hist[edges+1]  <= funct3D;
    edges             <= edges + 1;
  end

  // Compare every output of both instances against the model.
  always @(negedge clk) begin
    ctl_t d, e, m1, w1, w3;
    logic pc;
    if (edges >= 1) begin
      d  = model_dec(opD, funct3D, funct7D);
      e  = e_hist[edges];
      pc = e.jmp | (e.br & taken(f3_hist[edges], ZeroE, LessThanE, LessThanUE));
      m1 = late(edges, 0);
      w1 = late(edges, 1);
      w3 = late(edges, 3);
      chk("d1.ImmSrcD", imm1, d.imm);          chk("d3.ImmSrcD", imm3, d.imm);
      chk("d1.IllegalD", ill1, d.ill);         chk("d3.IllegalD", ill3, d.ill);
      chk("d1.ALUControlE", alu1, e.alu);      chk("d3.ALUControlE", alu3, e.alu);
      chk("d1.ALUSrcE", asrc1, e.asrc);        chk("d3.ALUSrcE", asrc3, e.asrc);
      chk("d1.JalrE", jalr1, e.jalr);          chk("d3.JalrE", jalr3, e.jalr);
      chk("d1.PCSrcE", pc1, pc);               chk("d3.PCSrcE", pc3, pc);
      chk("d1.ResultSrcE0", rse1, e.rs[0]);    chk("d3.ResultSrcE0", rse3, e.rs[0]);
      chk("d1.MemWriteM", mw1, m1.mw);         chk("d3.MemWriteM", mw3, m1.mw);
      chk("d1.RegWriteM", rwm1, m1.rw);        chk("d3.RegWriteM", rwm3, m1.rw);
      chk("d1.RegWriteW", rww1, w1.rw);        chk("d3.RegWriteW", rww3, w3.rw);
      chk("d1.ResultSrcW", rsw1, w1.rs);       chk("d3.ResultSrcW", rsw3, w3.rs);
      chk("d1.IllegalW", illw1, w1.ill);       chk("d3.IllegalW", illw3, w3.ill);
    end
  end

  // Inputs for the next edge; returns 1 time unit after that edge with inputs still held.
  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input bit fl = 1'b0, input bit r = 1'b0, input bit cz = 1'b0,
                       input bit clt = 1'b0, input bit cltu = 1'b0);
    opD = op; funct3D = f3; funct7D = f7; FlushE = fl; rst = r;
    ZeroE = cz; LessThanE = clt; LessThanUE = cltu;
    @(posedge clk);
    #1;
  endtask

  logic [16:0] enc [19] = '{
    {OP_R, 3'd0, 7'h00}, {OP_R, 3'd0, 7'h20}, {OP_R, 3'd7, 7'h00}, {OP_R, 3'd4, 7'h00},
    {OP_I, 3'd0, 7'h11}, {OP_I, 3'd5, 7'h20}, {OP_I, 3'd1, 7'h00}, {OP_LW, 3'd2, 7'h00},
    {OP_SW, 3'd2, 7'h00}, {OP_JAL, 3'd3, 7'h05}, {OP_JR, 3'd0, 7'h00}, {OP_BR, 3'd0, 7'h00},
    {OP_BR, 3'd1, 7'h00}, {OP_BR, 3'd4, 7'h00}, {OP_BR, 3'd6, 7'h00}, {OP_LUI, 3'd2, 7'h7f},
    {7'h7f, 3'd0, 7'h00}, {OP_R, 3'd1, 7'h00}, {OP_R, 3'd0, 7'h01}
  };

  initial begin
    logic [16:0] en;
    logic [2:0]  bf3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    // op f3 any f7 any | rw rs mw jmp br jalr alu asrc imm
    add(OP_R, 3'd0, 0, 7'h00, 0, 1, 2'b00, 0, 0, 0, 0, 4'd0, 0, 3'd0);
    add(OP_R, 3'd0, 0, 7'h20, 0, 1, 2'b00, 0, 0, 0, 0, 4'd1, 0, 3'd0);
    add(OP_R, 3'd7, 0, 7'h00, 0, 1, 2'b00, 0, 0, 0, 0, 4'd2, 0, 3'd0);
    add(OP_R, 3'd6, 0, 7'h00, 0, 1, 2'b00, 0, 0, 0, 0, 4'd3, 0, 3'd0);
    add(OP_R, 3'd3, 0, 7'h00, 0, 1, 2'b00, 0, 0, 0, 0, 4'd4, 0, 3'd0);
    add(OP_R, 3'd2, 0, 7'h00, 0, 1, 2'b00, 0, 0, 0, 0, 4'd5, 0, 3'd0);
    add(OP_R, 3'd4, 0, 7'h00, 0, 1, 2'b00, 0, 0, 0, 0, 4'd6, 0, 3'd0);
    add(OP_I, 3'd0, 0, 7'h00, 1, 1, 2'b00, 0, 0, 0, 0, 4'd0, 1, 3'd0);
    add(OP_I, 3'd7, 0, 7'h00, 1, 1, 2'b00, 0, 0, 0, 0, 4'd2, 1, 3'd0);
    add(OP_I, 3'd6, 0, 7'h00, 1, 1, 2'b00, 0, 0, 0, 0, 4'd3, 1, 3'd0);
    add(OP_I, 3'd3, 0, 7'h00, 1, 1, 2'b00, 0, 0, 0, 0, 4'd4, 1, 3'd0);
    add(OP_I, 3'd2, 0, 7'h00, 1, 1, 2'b00, 0, 0, 0, 0, 4'd5, 1, 3'd0);
    add(OP_I, 3'd4, 0, 7'h00, 1, 1, 2'b00, 0, 0, 0, 0, 4'd6, 1, 3'd0);
`ifdef CTRL_SHIFT_EN
    add(OP_R, 3'd1, 0, 7'h00, 0, 1, 2'b00, 0, 0, 0, 0, 4'd8, 0, 3'd0);
    add(OP_R, 3'd5, 0, 7'h00, 0, 1, 2'b00, 0, 0, 0, 0, 4'd9, 0, 3'd0);
    add(OP_R, 3'd5, 0, 7'h20, 0, 1, 2'b00, 0, 0, 0, 0, 4'd10, 0, 3'd0);
    add(OP_I, 3'd1, 0, 7'h00, 0, 1, 2'b00, 0, 0, 0, 0, 4'd8, 1, 3'd0);
    add(OP_I, 3'd5, 0, 7'h00, 0, 1, 2'b00, 0, 0, 0, 0, 4'd9, 1, 3'd0);
    add(OP_I, 3'd5, 0, 7'h20, 0, 1, 2'b00, 0, 0, 0, 0, 4'd10, 1, 3'd0);
`endif
    add(OP_LW, 3'd2, 0, 7'h00, 1, 1, 2'b01, 0, 0, 0, 0, 4'd0, 1, 3'd0);
    add(OP_SW, 3'd2, 0, 7'h00, 1, 0, 2'b00, 1, 0, 0, 0, 4'd0, 1, 3'd1);
    add(OP_JAL, 3'd0, 1, 7'h00, 1, 1, 2'b10, 0, 1, 0, 0, 4'd0, 0, 3'd4);
    add(OP_JR, 3'd0, 0, 7'h00, 1, 1, 2'b10, 0, 1, 0, 1, 4'd0, 1, 3'd0);
    add(OP_LUI, 3'd0, 1, 7'h00, 1, 1, 2'b11, 0, 0, 0, 0, 4'd0, 0, 3'd3);
    foreach (bf3[i]) add(OP_BR, bf3[i], 0, 7'h00, 1, 0, 2'b00, 0, 0, 1, 0, 4'd1, 0, 3'd2);

    // T1: reset with a jump in D and branch conditions asserted.
    drive(OP_JAL, 3'd0, 7'h00, 0, 1, 1, 1, 1);
    drive(OP_JAL, 3'd0, 7'h00, 0, 1, 1, 1, 1);
    chk("t1_pcsrc", pc1, 1'b0);
    chk("t1_regwritew3", rww3, 1'b0);
    chk("t1_illegalw1", illw1, 1'b0);

    // T2: decode sequence and pipeline latency.
    drive(OP_R, 3'd0, 7'h00);
    chk("t2_add_alu", alu1, 3'd0);
    drive(OP_R, 3'd0, 7'h20);
    chk("t2_sub_alu", alu1, 3'd1);
    drive(OP_LW, 3'd2, 7'h00);
    chk("t2_lw_rse0", rse1, 1'b1);
    chk("t2_lw_asrc", asrc3, 1'b1);
    drive(OP_SW, 3'd2, 7'h00);
    chk("t2_sw_imm", imm1, 3'b001);
    drive(OP_JAL, 3'd0, 7'h00);
    chk("t2_sw_memwritem", mw1, 1'b1);
    chk("t2_lw_resultsrcw1", rsw1, 2'b01);
    chk("t2_lw_regwritew1", rww1, 1'b1);
    chk("t2_jal_pcsrc", pc1, 1'b1);
    drive(OP_JR, 3'd0, 7'h00);
    chk("t2_jalr_jalre", jalr1, 1'b1);
    drive(OP_LUI, 3'd0, 7'h00);
    chk("t2_lui_imm", imm3, 3'b011);
    chk("t2_lw_resultsrcw3", rsw3, 2'b01);
    repeat (5) drive(OP_R, 3'd0, 7'h00, 1);

    // T3: every branch funct3 against every condition combination.
    foreach (bf3[i]) begin
      for (int c = 0; c < 8; c++) begin
        drive(OP_BR, bf3[i], 7'h00, 0, 0, c[0], c[1], c[2]);
      end
    end
    drive(OP_BR, 3'd0, 7'h00, 0, 0, 1, 0, 0);
    chk("t3_beq_taken", pc1, 1'b1);
    drive(OP_BR, 3'd7, 7'h00, 0, 0, 0, 0, 1);
    chk("t3_bgeu_not_taken", pc3, 1'b0);
    drive(OP_BR, 3'd2, 7'h00, 0, 0, 1, 1, 1);
    chk("t3_f3_010_illegal", ill1, 1'b1);
    chk("t3_f3_010_pcsrc", pc1, 1'b0);

    // T4: flush beats a valid decode; reset with flush acts as reset.
    drive(OP_BR, 3'd0, 7'h00, 1, 0, 1, 0, 0);
    chk("t4_flush_beq", pc1, 1'b0);
    drive(OP_JAL, 3'd0, 7'h00, 1, 0, 1, 0, 0);
    chk("t4_flush_jal", pc3, 1'b0);
    drive(OP_JAL, 3'd0, 7'h00, 1, 1, 1, 0, 0);
    chk("t4_rst_flush", pc1, 1'b0);
    repeat (4) drive(OP_R, 3'd0, 7'h00, 1);
    chk("t4_regwritew3", rww3, 1'b0);

    // T5: illegal opcode retires with no writes.
    drive(7'h7f, 3'd0, 7'h00);
    chk("t5_illegald", ill3, 1'b1);
    repeat (2) drive(OP_R, 3'd0, 7'h00, 1);
    chk("t5_illegalw1", illw1, 1'b1);
    chk("t5_regwritew1", rww1, 1'b0);
    repeat (2) drive(OP_R, 3'd0, 7'h00, 1);
    chk("t5_illegalw3", illw3, 1'b1);

    // T6: shift decoding depends on configuration.
    drive(OP_R, 3'd5, 7'h20);
`ifdef CTRL_SHIFT_EN
    chk("t6_sra_alu", alu1, 4'd10);
`else
    chk("t6_sra_illegal", ill1, 1'b1);
`endif
    drive(OP_I, 3'd1, 7'h01);
    chk("t6_slli_badimm", ill1, 1'b1);
    drive(OP_R, 3'd0, 7'h01);
    chk("t6_r_badf7", ill3, 1'b1);
    drive(OP_LW, 3'd2, 7'h00);
    repeat (6) drive(OP_R, 3'd0, 7'h00, 1);

    // Mixed traffic with random flushes, conditions and one reset.
    for (int i = 0; i < 80; i++) begin
      en = enc[$urandom_range(0, 18)];
      drive(en[16:10], en[9:7], en[6:0], ($urandom_range(0, 3) == 0), (i == 40),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (6) drive(OP_R, 3'd0, 7'h00, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
